// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: control-side driver for the ALU FunSel/WF/flags interface.
// Accepts one instruction, checks its condition code against the live ALU flags,
// runs the op for one or more EXEC cycles (shifts/rotates repeat), waits one
// SETTLE cycle for the flags to land, then offers Result/ResFlags until taken.
module alu_op_sequencer #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 5
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              InstValid,
  output logic              InstReady,
  input  logic [4:0]        InstFunSel,
  input  logic [DATA_W-1:0] InstA,
  input  logic [DATA_W-1:0] InstB,
  input  logic [CNT_W-1:0]  InstCount,
  input  logic              InstSetF,
  input  logic [2:0]        InstCond,
  output logic [DATA_W:0]   AluA,
  output logic [DATA_W:0]   AluB,
  output logic [4:0]        FunSel,
  output logic              WF,
  input  logic [DATA_W:0]   AluOut,
  input  logic [3:0]        FlagsIn,
  output logic              ResValid,
  input  logic              ResReady,
  output logic [DATA_W-1:0] Result,
  output logic [3:0]        ResFlags,
  output logic              Skipped,
  output logic              Busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EXEC   = 2'd1,
    S_SETTLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t             state;
  logic [DATA_W-1:0]  acc;
  logic [DATA_W-1:0]  b_q;
  logic [CNT_W-1:0]   cnt;
  logic [4:0]         fun_sel_q;
  logic               wf_q;
  logic               rdy_q;
  logic               vld_q;
  logic [DATA_W-1:0]  res_q;
  logic [3:0]         res_flags_q;
  logic               skip_q;
  logic               alu_out_msb_unused;

  // Condition codes over {Z,C,N,O}; NV never passes.
  function automatic logic cond_pass(input logic [2:0] cond, input logic [3:0] flags);
    logic z, c, n, o;
    {z, c, n, o} = flags;
    case (cond)
      3'b000:  cond_pass = 1'b1;
      3'b001:  cond_pass = z;
      3'b010:  cond_pass = !z;
      3'b011:  cond_pass = c;
      3'b100:  cond_pass = !c;
      3'b101:  cond_pass = n;
      3'b110:  cond_pass = o;
      default: cond_pass = 1'b0;
    endcase
  endfunction

  // Only shift/rotate codes repeat; a zero count still runs once.
  function automatic logic [CNT_W-1:0] eff_count(input logic [3:0] op,
                                                 input logic [CNT_W-1:0] count);
    if (op < 4'b1011 || count == '0)
      eff_count = CNT_W'(1);
    else
      eff_count = count;
  endfunction

  assign alu_out_msb_unused = AluOut[DATA_W];

  assign AluA      = {1'b0, acc};
  assign AluB      = {1'b0, b_q};
  assign FunSel    = fun_sel_q;
  assign WF        = wf_q;
  assign InstReady = rdy_q;
  assign ResValid  = vld_q;
  assign Result    = res_q;
  assign ResFlags  = res_flags_q;
  assign Skipped   = skip_q;
  assign Busy      = (state != S_IDLE);

  // Sequencer FSM with registered ALU drive and result outputs.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state       <= S_IDLE;
      acc         <= '0;
      b_q         <= '0;
      cnt         <= '0;
      fun_sel_q   <= '0;
      wf_q        <= 1'b0;
      rdy_q       <= 1'b0;
      vld_q       <= 1'b0;
      res_q       <= '0;
      res_flags_q <= '0;
      skip_q      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          rdy_q <= 1'b1;
          if (InstValid && rdy_q) begin
            rdy_q  <= 1'b0;
            acc    <= InstA;
            b_q    <= InstB;
            cnt    <= eff_count(InstFunSel[3:0], InstCount);
            skip_q <= 1'b0;
            if (cond_pass(InstCond, FlagsIn)) begin
              state     <= S_EXEC;
              fun_sel_q <= InstFunSel;
              wf_q      <= InstSetF;
            end else begin
              // Failed condition: report operand A untouched, ALU never driven.
              state       <= S_DONE;
              skip_q      <= 1'b1;
              res_q       <= InstA;
              res_flags_q <= FlagsIn;
              vld_q       <= 1'b1;
            end
          end
        end
        S_EXEC: begin
          acc <= AluOut[DATA_W-1:0];
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state     <= S_SETTLE;
            fun_sel_q <= '0;
            wf_q      <= 1'b0;
          end
        end
        S_SETTLE: begin
          // Flags written on the last EXEC edge are now visible on FlagsIn.
          res_q       <= acc;
          res_flags_q <= FlagsIn;
          vld_q       <= 1'b1;
          state       <= S_DONE;
        end
        default: begin
          if (ResReady) begin
            vld_q <= 1'b0;
            rdy_q <= 1'b1;
            state <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: a behavioural ALU stub closes the loop on
// AluA/AluB/FunSel/WF, and a rule-level reference model predicts each result.
module tb_alu_op_sequencer;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 5;

  logic              Clock = 1'b0;
  logic              Reset = 1'b0;
  logic              InstValid = 1'b0;
  logic              InstReady;
  logic [4:0]        InstFunSel = '0;
  logic [DATA_W-1:0] InstA = '0;
  logic [DATA_W-1:0] InstB = '0;
  logic [CNT_W-1:0]  InstCount = '0;
  logic              InstSetF = 1'b0;
  logic [2:0]        InstCond = '0;
  logic [DATA_W:0]   AluA, AluB, AluOut;
  logic [4:0]        FunSel;
  logic              WF;
  logic [3:0]        FlagsIn;
  logic              ResValid;
  logic              ResReady = 1'b0;
  logic [DATA_W-1:0] Result;
  logic [3:0]        ResFlags;
  logic              Skipped, Busy;

  int vectors = 0;
  int miscompares = 0;

  alu_op_sequencer #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .Clock(Clock), .Reset(Reset), .InstValid(InstValid), .InstReady(InstReady),
    .InstFunSel(InstFunSel), .InstA(InstA), .InstB(InstB), .InstCount(InstCount),
    .InstSetF(InstSetF), .InstCond(InstCond), .AluA(AluA), .AluB(AluB),
    .FunSel(FunSel), .WF(WF), .AluOut(AluOut), .FlagsIn(FlagsIn),
    .ResValid(ResValid), .ResReady(ResReady), .Result(Result), .ResFlags(ResFlags),
    .Skipped(Skipped), .Busy(Busy)
  );

  always #5 Clock = ~Clock;

  typedef struct packed { logic [31:0] res; logic [3:0] fl; } alu_r_t;

  // One ALU step; flags {Z,C,N,O}. Narrow ops work on 16 bits and sign-extend.
  function automatic alu_r_t alu_f(input logic [4:0] fs, input logic [31:0] a,
                                   input logic [31:0] b, input logic [3:0] fl);
    alu_r_t o;
    logic [32:0] r;
    logic [31:0] m, am, bm, bo, res;
    int s;
    logic c, v;
    s  = fs[4] ? 31 : 15;
    m  = fs[4] ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    am = a & m;
    bm = b & m;
    bo = (fs[3:0] == 4'h6) ? (~bm & m) : bm;
    c  = fl[2];
    v  = fl[0];
    r  = '0;
    case (fs[3:0])
      4'h0: r = {1'b0, am};
      4'h1: r = {1'b0, bm};
      4'h2: r = {1'b0, ~am & m};
      4'h3: r = {1'b0, ~bm & m};
      4'h4, 4'h5, 4'h6: begin
        r = {1'b0, am} + {1'b0, bo} +
            ((fs[3:0] == 4'h5) ? {32'b0, c} : (fs[3:0] == 4'h6) ? 33'd1 : 33'd0);
        c = fs[4] ? r[32] : r[16];
        v = (am[s] == bo[s]) && (r[s] != am[s]);
      end
      4'h7: r = {1'b0, am & bm};
      4'h8: r = {1'b0, am | bm};
      4'h9: r = {1'b0, am ^ bm};
      4'hA: r = {1'b0, ~(am & bm) & m};
      4'hB: begin r = {1'b0, (am << 1) & m}; c = am[s]; end
      4'hC: begin r = {1'b0, am >> 1}; c = am[0]; end
      4'hD: begin r = {1'b0, (am >> 1) | ({31'b0, am[s]} << s)}; c = am[0]; end
      4'hE: begin r = {1'b0, ((am << 1) & m) | {31'b0, c}}; c = am[s]; end
      default: begin r = {1'b0, (am >> 1) | ({31'b0, c} << s)}; c = am[0]; end
    endcase
    res = r[31:0] & m;
    o.fl = {(res == 32'b0), c, res[s], v};
    if (!fs[4]) res = {{16{res[15]}}, res[15:0]};
    o.res = res;
    return o;
  endfunction

  logic [3:0] alu_flags;
  logic       flag_load = 1'b0;
  logic [3:0] flag_val = '0;
  alu_r_t     alu_now;

  assign alu_now = alu_f(FunSel, AluA[31:0], AluB[31:0], alu_flags);
  assign AluOut  = {1'b1, alu_now.res};
  assign FlagsIn = alu_flags;

  // ALU flag register: written by WF, or preset by the bench while idle.
  always @(posedge Clock) begin
    if (flag_load) alu_flags <= flag_val;
    else if (WF)   alu_flags <= alu_now.fl;
  end

  typedef struct { logic [31:0] res; logic [3:0] fl; logic skip; int n; int wf; int lat; } exp_t;
  typedef struct { logic [31:0] res; logic [3:0] fl; logic skip; int n; int wf; int lat; int bad; logic tmo; } obs_t;

  // Reference: condition on accept-time flags, then apply the op n times.
  function automatic exp_t ref_op(input logic [4:0] fs, input logic [31:0] a, input logic [31:0] b,
                                  input logic [4:0] cnt, input logic setf, input logic [2:0] cond,
                                  input logic [3:0] fl);
    exp_t e;
    logic pass;
    logic [31:0] acc;
    alu_r_t r;
    case (cond)
      3'd0: pass = 1'b1;
      3'd1: pass = fl[3];
      3'd2: pass = !fl[3];
      3'd3: pass = fl[2];
      3'd4: pass = !fl[2];
      3'd5: pass = fl[1];
      3'd6: pass = fl[0];
      default: pass = 1'b0;
    endcase
    e.fl = fl;
    if (!pass) begin
      e.res = a; e.skip = 1'b1; e.n = 0; e.wf = 0; e.lat = 1;
      return e;
    end
    e.skip = 1'b0;
    e.n = (fs[3:0] >= 4'hB && cnt != 0) ? int'(cnt) : 1;
    acc = a;
    for (int i = 0; i < e.n; i++) begin
      r = alu_f(fs, acc, b, e.fl);
      acc = r.res;
      if (setf) e.fl = r.fl;
    end
    e.res = acc;
    e.wf  = setf ? e.n : 0;
    e.lat = e.n + 2;
    return e;
  endfunction

  task automatic set_flags(input logic [3:0] v);
    @(negedge Clock);
    flag_load = 1'b1; flag_val = v;
    @(negedge Clock);
    flag_load = 1'b0;
  endtask

  // Drive one instruction, watch it run, hold the result for 'hold' cycles, take it.
  task automatic run_op(input logic [4:0] fs, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] cnt, input logic setf, input logic [2:0] cond,
                        input int hold, output obs_t o);
    o = '{res: 0, fl: 0, skip: 0, n: 0, wf: 0, lat: 0, bad: 0, tmo: 0};
    @(negedge Clock);
    for (int i = 0; i < 50 && !InstReady; i++) @(negedge Clock);
    InstValid = 1'b1; InstFunSel = fs; InstA = a; InstB = b;
    InstCount = cnt; InstSetF = setf; InstCond = cond;
    @(negedge Clock);
    InstValid = 1'b0; InstA = $urandom; InstB = $urandom;
    o.lat = 1;
    while (!ResValid && o.lat < 100) begin
      if (FunSel !== 5'b0) begin
        o.n++;
        if (FunSel !== fs || AluB !== {1'b0, b}) o.bad++;
      end
      if (WF) o.wf++;
      @(negedge Clock);
      o.lat++;
    end
    o.tmo  = !ResValid;
    o.res  = Result; o.fl = ResFlags; o.skip = Skipped;
    for (int i = 0; i < hold; i++) begin
      InstValid = 1'b1; InstFunSel = 5'($urandom); InstA = $urandom; InstCond = 3'b000;
      @(negedge Clock);
      if (Result !== o.res || ResFlags !== o.fl || Skipped !== o.skip || ResValid !== 1'b1 ||
          InstReady !== 1'b0 || WF !== 1'b0 || FunSel !== 5'b0 || Busy !== 1'b1) o.bad++;
    end
    InstValid = 1'b0; ResReady = 1'b1;
    @(negedge Clock);
    ResReady = 1'b0;
    if (ResValid !== 1'b0 || Busy !== 1'b0 || InstReady !== 1'b1) o.bad++;
  endtask

  task automatic test_reset;
    flag_load = 1'b1; flag_val = 4'b0000;
    repeat (2) @(negedge Clock);
    flag_load = 1'b0;
    vectors++;
    if ({InstReady, FunSel, WF, AluA, AluB, ResValid, Result, ResFlags, Skipped, Busy} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs got rdy=%b fs=%b wf=%b a=%h b=%h v=%b r=%h f=%b s=%b busy=%b want all zero",
               InstReady, FunSel, WF, AluA, AluB, ResValid, Result, ResFlags, Skipped, Busy);
    end
    Reset = 1'b1;
    repeat (2) @(negedge Clock);
    vectors++;
    if (InstReady !== 1'b1) begin
      miscompares++; $display("FAIL reset_ready got %b want 1", InstReady);
    end
  endtask

  task automatic test_add_wide;
    obs_t o;
    run_op(5'b10100, 32'hFFFF_FFFF, 32'h1, 5'd0, 1'b1, 3'b000, 0, o);
    vectors++; if (o.res !== 32'h0) begin miscompares++; $display("FAIL add_result got %h want 00000000", o.res); end
    vectors++; if (o.fl[3] !== 1'b1) begin miscompares++; $display("FAIL add_zflag got %b want Z=1", o.fl); end
    vectors++; if (o.lat !== 3) begin miscompares++; $display("FAIL add_latency got %0d want 3", o.lat); end
    vectors++; if (o.wf !== 1 || o.n !== 1) begin miscompares++; $display("FAIL add_wf_exec got wf=%0d exec=%0d want 1/1", o.wf, o.n); end
    vectors++; if (o.bad !== 0 || o.tmo) begin miscompares++; $display("FAIL add_protocol got bad=%0d tmo=%b want 0/0", o.bad, o.tmo); end
  endtask

  task automatic test_lsr_repeat;
    obs_t o;
    run_op(5'b11100, 32'h0000_00F0, 32'h0, 5'd4, 1'b0, 3'b000, 0, o);
    vectors++; if (o.res !== 32'h0000_000F) begin miscompares++; $display("FAIL lsr_result got %h want 0000000f", o.res); end
    vectors++; if (o.n !== 4) begin miscompares++; $display("FAIL lsr_exec got %0d want 4", o.n); end
    vectors++; if (o.lat !== 6 || o.wf !== 0) begin miscompares++; $display("FAIL lsr_lat_wf got lat=%0d wf=%0d want 6/0", o.lat, o.wf); end
    vectors++; if (o.bad !== 0 || o.tmo) begin miscompares++; $display("FAIL lsr_protocol got bad=%0d tmo=%b want 0/0", o.bad, o.tmo); end
  endtask

  task automatic test_skip;
    obs_t o;
    set_flags(4'b0110);
    run_op(5'b10100, 32'h1234_5678, 32'h9, 5'd0, 1'b1, 3'b001, 3, o);
    vectors++; if (o.lat !== 1 || o.skip !== 1'b1) begin miscompares++; $display("FAIL skip_lat got lat=%0d skip=%b want 1/1", o.lat, o.skip); end
    vectors++; if (o.res !== 32'h1234_5678) begin miscompares++; $display("FAIL skip_result got %h want 12345678", o.res); end
    vectors++; if (o.wf !== 0 || o.n !== 0 || o.fl !== 4'b0110) begin miscompares++; $display("FAIL skip_no_exec got wf=%0d exec=%0d fl=%b want 0/0/0110", o.wf, o.n, o.fl); end
    vectors++; if (o.bad !== 0) begin miscompares++; $display("FAIL skip_protocol got bad=%0d want 0", o.bad); end
  endtask

  task automatic test_backpressure;
    obs_t o;
    exp_t e;
    e = ref_op(5'b10110, 32'h0000_0005, 32'h0000_0007, 5'd0, 1'b1, 3'b000, alu_flags);
    run_op(5'b10110, 32'h0000_0005, 32'h0000_0007, 5'd0, 1'b1, 3'b000, 5, o);
    vectors++; if (o.res !== e.res || o.fl !== e.fl) begin miscompares++; $display("FAIL bp_result got %h/%b want %h/%b", o.res, o.fl, e.res, e.fl); end
    vectors++; if (o.bad !== 0 || o.tmo) begin miscompares++; $display("FAIL bp_stable got bad=%0d tmo=%b want 0/0", o.bad, o.tmo); end
  endtask

  task automatic test_reset_mid_op;
    obs_t o;
    exp_t e;
    int seen;
    @(negedge Clock);
    InstValid = 1'b1; InstFunSel = 5'b11100; InstA = 32'hDEAD_BEEF; InstB = 32'h0;
    InstCount = 5'd8; InstSetF = 1'b1; InstCond = 3'b000;
    repeat (3) begin
      @(negedge Clock);
      InstValid = 1'b0;
    end
    Reset = 1'b0;
    #1;
    vectors++;
    if ({InstReady, FunSel, WF, AluA, AluB, ResValid, Result, ResFlags, Skipped, Busy} !== '0) begin
      miscompares++;
      $display("FAIL midreset_outputs got fs=%b wf=%b a=%h v=%b busy=%b want all zero", FunSel, WF, AluA, ResValid, Busy);
    end
    @(negedge Clock);
    Reset = 1'b1;
    seen = 0;
    repeat (12) begin
      @(negedge Clock);
      if (ResValid || Busy) seen++;
    end
    vectors++; if (seen !== 0) begin miscompares++; $display("FAIL midreset_no_result got %0d active cycles want 0", seen); end
    e = ref_op(5'b11011, 32'h8000_0003, 32'h0, 5'd3, 1'b1, 3'b000, alu_flags);
    run_op(5'b11011, 32'h8000_0003, 32'h0, 5'd3, 1'b1, 3'b000, 0, o);
    vectors++; if (o.res !== e.res || o.fl !== e.fl || o.n !== 3) begin miscompares++; $display("FAIL midreset_next_op got %h/%b/%0d want %h/%b/3", o.res, o.fl, o.n, e.res, e.fl); end
  endtask

  task automatic test_single_exec;
    obs_t o;
    exp_t e;
    e = ref_op(5'b11101, 32'h8000_0010, 32'h0, 5'd0, 1'b0, 3'b000, alu_flags);
    run_op(5'b11101, 32'h8000_0010, 32'h0, 5'd0, 1'b0, 3'b000, 0, o);
    vectors++; if (o.n !== 1 || o.res !== 32'hC000_0008) begin miscompares++; $display("FAIL count0_shift got exec=%0d res=%h want 1/c0000008", o.n, o.res); end
    e = ref_op(5'b10111, 32'hF0F0_FFFF, 32'h0FF0_00FF, 5'd7, 1'b1, 3'b000, alu_flags);
    run_op(5'b10111, 32'hF0F0_FFFF, 32'h0FF0_00FF, 5'd7, 1'b1, 3'b000, 0, o);
    vectors++; if (o.n !== 1 || o.res !== 32'h00F0_00FF || o.wf !== 1) begin miscompares++; $display("FAIL and_count7 got exec=%0d res=%h wf=%0d want 1/00f000ff/1", o.n, o.res, o.wf); end
    vectors++; if (o.fl !== e.fl || o.lat !== 3) begin miscompares++; $display("FAIL and_flags got %b lat=%0d want %b lat=3", o.fl, o.lat, e.fl); end
  endtask

  task automatic test_random;
    obs_t o;
    exp_t e;
    logic [4:0] fs;
    logic [31:0] a, b;
    logic [4:0] cnt;
    logic setf;
    logic [2:0] cond;
    for (int k = 0; k < 24; k++) begin
      set_flags(4'($urandom));
      fs = 5'($urandom);
      if (fs == 5'b0) fs = 5'b10000;
      a = $urandom; b = $urandom;
      cnt = 5'($urandom_range(0, 9));
      setf = 1'($urandom);
      cond = 3'($urandom);
      e = ref_op(fs, a, b, cnt, setf, cond, alu_flags);
      run_op(fs, a, b, cnt, setf, cond, $urandom_range(0, 2), o);
      vectors++;
      if (o.res !== e.res || o.fl !== e.fl || o.skip !== e.skip) begin
        miscompares++;
        $display("FAIL rand%0d_result fs=%b cnt=%0d got %h/%b/%b want %h/%b/%b", k, fs, cnt, o.res, o.fl, o.skip, e.res, e.fl, e.skip);
      end
      vectors++;
      if (o.n !== e.n || o.wf !== e.wf || o.lat !== e.lat || o.bad !== 0 || o.tmo) begin
        miscompares++;
        $display("FAIL rand%0d_timing got exec=%0d wf=%0d lat=%0d bad=%0d want %0d/%0d/%0d/0", k, o.n, o.wf, o.lat, o.bad, e.n, e.wf, e.lat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add_wide();
    test_lsr_repeat();
    test_skip();
    test_backpressure();
    test_reset_mid_op();
    test_single_exec();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
